otp_seq_ctrl: RTL and testbench

OTP_SEQ_CTRL -- requirements
Module: otp_seq_ctrl

---
 rtl/otp_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_otp_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/otp_seq_ctrl.sv
// otp_seq_ctrl: OTP macro read/program sequencer behind a valid/ready request/response pair.
// Define OTP_SEQ_CTRL_PGM_VERIFY_EN to add a read-back verify after every program.
module otp_seq_ctrl #(
    parameter int OTP_ADDR_W = 14,
    parameter int OTP_DATA_W = 32,
    parameter int T_RST      = 2,
    parameter int T_SU       = 2,
    parameter int T_RD       = 4,
    parameter int T_PUMP     = 8,
    parameter int T_PGM      = 16,
    parameter int T_DIS      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [OTP_ADDR_W-1:0] i_req_addr,
    input  logic                  i_pgm_allow,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [OTP_DATA_W-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic [OTP_ADDR_W-1:0] o_otp_addr,
    output logic                  o_otp_rstb,
    output logic                  o_otp_ceb,
    output logic                  o_otp_cle,
    output logic                  o_otp_cpumpen,
    output logic                  o_otp_pgmen,
    output logic                  o_otp_dle,
    output logic                  o_otp_din,
    output logic                  o_otp_readen,
    output logic                  o_otp_web,
    output logic                  o_otp_vddrdy,
    output logic                  o_otp_clken,
    input  logic [OTP_DATA_W-1:0] i_otp_dout
);
    typedef enum logic [3:0] {IDLE, RST, SETUP, READ, LATCH, PUMP, PGM, DISCH, RESP} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [OTP_ADDR_W-1:0]   addr_q, addr_d;
    logic [OTP_DATA_W-1:0]   data_q, data_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic                    live_q;
    logic                    done;

    assign done = cnt_q == 16'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = done ? 16'd0 : cnt_q - 16'd1;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (i_req_valid && o_req_ready) begin
                write_d = i_req_write;
                data_d  = '0;
                err_d   = i_req_write && !i_pgm_allow;
                state_d = (i_req_write && !i_pgm_allow) ? RESP : RST;
                addr_d  = (i_req_write && !i_pgm_allow) ? addr_q : i_req_addr;
            end
            RST:   if (done) state_d = write_q ? LATCH : SETUP;
            SETUP: if (done) state_d = READ;
            READ:  if (done) begin
                state_d = RESP;
                data_d  = write_q ? '0 : i_otp_dout;
                err_d   = write_q && !i_otp_dout[addr_q[4:0]];
            end
            LATCH: if (done) state_d = PUMP;
            PUMP:  if (done) state_d = PGM;
            PGM:   if (done) state_d = DISCH;
`ifdef OTP_SEQ_CTRL_PGM_VERIFY_EN
            DISCH: if (done) state_d = SETUP;
`else
            DISCH: if (done) state_d = RESP;
`endif
            RESP:  if (done && i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // RESP loads 1 so the response appears one cycle after entry
        if (state_d != state_q)
            cnt_d = state_d == RST   ? 16'(T_RST - 1)  :
                    state_d == SETUP ? 16'(T_SU - 1)   :
                    state_d == READ  ? 16'(T_RD - 1)   :
                    state_d == LATCH ? 16'd1           :
                    state_d == PUMP  ? 16'(T_PUMP - 1) :
                    state_d == PGM   ? 16'(T_PGM - 1)  :
                    state_d == DISCH ? 16'(T_DIS - 1)  :
                    state_d == RESP  ? 16'd1           : 16'd0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    assign o_req_ready   = live_q && state_q == IDLE;
    assign o_rsp_valid   = state_q == RESP && done;
    assign o_rsp_data    = data_q;
    assign o_rsp_err     = err_q;
    assign o_otp_addr    = addr_q;
    assign o_otp_rstb    = live_q && state_q != RST;
    assign o_otp_ceb     = !(state_q inside {SETUP, READ, LATCH, PUMP, PGM, DISCH});
    assign o_otp_cle     = 1'b0;
    assign o_otp_cpumpen = state_q inside {PUMP, PGM};
    assign o_otp_pgmen   = state_q inside {PUMP, PGM};
    assign o_otp_dle     = state_q == LATCH && !done;
    assign o_otp_din     = state_q == LATCH && !done;
    assign o_otp_readen  = state_q == READ;
    assign o_otp_web     = !(o_otp_dle || state_q == PGM);
    assign o_otp_vddrdy  = 1'b0;
    assign o_otp_clken   = live_q;
endmodule

// File: tb/tb_otp_seq_ctrl.sv
// tb_otp_seq_ctrl: randomized self-checking bench for otp_seq_ctrl against a sequence-rule model.
module tb_otp_seq_ctrl;
    localparam int AW = 14, DW = 32;
    localparam int T_RST = 2, T_SU = 2, T_RD = 4, T_PUMP = 8, T_PGM = 16, T_DIS = 4;
`ifdef OTP_SEQ_CTRL_PGM_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic          i_clk = 1'b0, i_rst = 1'b1;
    logic          i_req_valid = 1'b0, i_req_write = 1'b0, i_pgm_allow = 1'b0, i_rsp_ready = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [DW-1:0] i_otp_dout = '0;
    logic          o_req_ready, o_rsp_valid, o_rsp_err;
    logic [DW-1:0] o_rsp_data;
    logic [AW-1:0] o_otp_addr;
    logic          o_otp_rstb, o_otp_ceb, o_otp_cle, o_otp_cpumpen, o_otp_pgmen, o_otp_dle;
    logic          o_otp_din, o_otp_readen, o_otp_web, o_otp_vddrdy, o_otp_clken;
    int            errors = 0, checks = 0;

    always #5 i_clk = ~i_clk;

    otp_seq_ctrl #(
        .OTP_ADDR_W(AW), .OTP_DATA_W(DW), .T_RST(T_RST), .T_SU(T_SU), .T_RD(T_RD),
        .T_PUMP(T_PUMP), .T_PGM(T_PGM), .T_DIS(T_DIS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_pgm_allow(i_pgm_allow),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err), .o_otp_addr(o_otp_addr), .o_otp_rstb(o_otp_rstb),
        .o_otp_ceb(o_otp_ceb), .o_otp_cle(o_otp_cle), .o_otp_cpumpen(o_otp_cpumpen),
        .o_otp_pgmen(o_otp_pgmen), .o_otp_dle(o_otp_dle), .o_otp_din(o_otp_din),
        .o_otp_readen(o_otp_readen), .o_otp_web(o_otp_web), .o_otp_vddrdy(o_otp_vddrdy),
        .o_otp_clken(o_otp_clken), .i_otp_dout(i_otp_dout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+10:0] pins();
        return {o_otp_addr, o_otp_rstb, o_otp_ceb, o_otp_cle, o_otp_cpumpen, o_otp_pgmen,
                o_otp_dle, o_otp_din, o_otp_readen, o_otp_web, o_otp_vddrdy, o_otp_clken};
    endfunction

    // Called and returns #1 after a rising edge with the controller idle.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic allow,
                           input logic [DW-1:0] dout, input int hold);
        logic          denied, prog, seen_pen, err0;
        logic [DW-1:0] data0;
        logic [AW+10:0] idle_pins;
        int lat, n_rd, n_latch, n_web, n_pgm, n_pen, n_gap, bad_inv, bad_addr, bad_idle, bad_hold;
        int exp_lat, exp_rd;
        logic exp_err;
        denied  = wr && !allow;
        prog    = wr && allow;
        exp_lat = denied ? 1 : prog ? T_RST + 2 + T_PUMP + T_PGM + T_DIS + 1 + VFY * (T_SU + T_RD)
                                    : T_RST + T_SU + T_RD + 1;
        exp_rd  = denied ? 0 : prog ? VFY * T_RD : T_RD;
        exp_err = denied ? 1'b1 : (prog && VFY == 1) ? !dout[addr[4:0]] : 1'b0;
        {lat, n_rd, n_latch, n_web, n_pgm, n_pen, n_gap} = '0;
        {bad_inv, bad_addr, bad_idle, bad_hold} = '0;
        seen_pen = 1'b0;
        i_otp_dout  = dout;
        i_req_write = wr;
        i_req_addr  = addr;
        i_pgm_allow = allow;
        i_req_valid = 1'b1;
        idle_pins   = pins();
        chk("ready_idle", o_req_ready, 1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_req_addr  = AW'($urandom);
        i_req_write = 1'($urandom);
        i_pgm_allow = 1'($urandom);
        while (!o_rsp_valid && lat < 300) begin
            n_rd    += int'(o_otp_readen);
            n_latch += int'(o_otp_dle && o_otp_din && !o_otp_web);
            n_web   += int'(!o_otp_web);
            n_pgm   += int'(!o_otp_web && o_otp_pgmen && o_otp_cpumpen);
            n_pen   += int'(o_otp_pgmen);
            seen_pen = seen_pen || o_otp_pgmen;
            n_gap   += int'(seen_pen && !o_otp_pgmen && !o_otp_cpumpen && !o_otp_ceb);
            bad_inv += int'((o_otp_readen && (o_otp_pgmen || o_otp_cpumpen)) ||
                            (o_otp_din && o_otp_readen) || o_otp_cle || o_otp_vddrdy || !o_otp_clken);
            bad_addr += int'(!denied && o_otp_addr !== addr);
            bad_idle += int'(denied && pins() !== idle_pins);
            @(posedge i_clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_data", o_rsp_data, wr ? '0 : dout);
        chk("rsp_err", o_rsp_err, exp_err);
        chk("readen_cycles", n_rd, exp_rd);
        chk("latch_cycles", n_latch, prog ? 1 : 0);
        chk("web_low_cycles", n_web, prog ? 1 + T_PGM : 0);
        chk("pgm_in_pump", n_pgm, prog ? T_PGM : 0);
        chk("pgmen_cycles", n_pen, prog ? T_PUMP + T_PGM : 0);
        chk("disch_cycles", n_gap, prog ? T_DIS + VFY * (T_SU + T_RD) : 0);
        chk("pin_rules", bad_inv, 0);
        if (denied) chk("idle_pins", bad_idle, 0);
        else chk("addr_stable", bad_addr, 0);
        data0 = o_rsp_data;
        err0  = o_rsp_err;
        for (int i = 0; i < hold; i++) begin
            i_rsp_ready = 1'b0;
            i_req_valid = 1'b1;
            @(posedge i_clk); #1;
            bad_hold += int'(!o_rsp_valid || o_rsp_data !== data0 || o_rsp_err !== err0 || o_req_ready);
        end
        if (hold > 0) chk("rsp_hold", bad_hold, 0);
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        chk("rsp_drop", o_rsp_valid, 0);
        chk("idle_return", {o_req_ready, o_otp_rstb, o_otp_ceb}, 3'b111);
    endtask

    initial begin
        int n, seen;
        #1;
        chk("rst_pins", pins(), {{AW{1'b0}}, 11'b01000000100});
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rsp", {o_rsp_valid, o_rsp_err, o_rsp_data}, '0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("release", {o_req_ready, o_otp_clken, o_otp_rstb}, 3'b111);

        run_txn(1'b0, 14'h0040, 1'b0, 32'hA5A5_5A5A, 0);
        run_txn(1'b1, 14'h0003, 1'b1, 32'hFFFF_FFFF, 0);
        run_txn(1'b1, 14'h0003, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, 14'h1ABC, 1'b1, 32'hDEAD_BEEF, 5);
        run_txn(1'b1, 14'h0003, 1'b1, 32'hFFFF_FFF7, 1);
        run_txn(1'b1, 14'h0003, 1'b1, 32'h0000_0008, 0);

        // abort a program in its fifth PGM cycle
        i_otp_dout  = 32'hFFFF_FFFF;
        i_req_write = 1'b1;
        i_pgm_allow = 1'b1;
        i_req_addr  = 14'h0003;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        n = 0;
        for (int g = 0; g < 100 && n < 5; g++) begin
            if (!o_otp_web && o_otp_pgmen) n++;
            if (n < 5) begin @(posedge i_clk); #1; end
        end
        chk("pgm_reach", n, 5);
        i_rst = 1'b1;
        #1;
        chk("abort_pins", {o_otp_pgmen, o_otp_cpumpen, o_otp_web, o_otp_ceb, o_otp_rstb,
                           o_otp_clken, o_req_ready, o_rsp_valid}, 8'b0011_0000);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("abort_release", {o_req_ready, o_otp_clken}, 2'b11);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen += int'(o_rsp_valid || !o_otp_rstb);
            @(posedge i_clk); #1;
        end
        chk("abort_no_rsp", seen, 0);
        run_txn(1'b0, 14'h0040, 1'b1, 32'hA5A5_5A5A, 0);

        for (int t = 0; t < 20; t++)
            run_txn(1'($urandom), AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
